vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 77 +++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Bundle of VGA raster signals passed from the timing generator to the draw stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered sync,
// blanking and line/frame pulses, all decoded from next-state counter values.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic clk,
    input  logic rst,
    vga_if.out   vga_out,
    output logic frame_start,
    output logic line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLK    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYN_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYN_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_BLK    = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYN_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYN_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
    logic        frame_start_q, line_start_q;

    // >= rather than == so a corrupted counter can never run past the wrap point
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q >= H_LAST) begin
            hcount_d = 11'd0;
            vcount_d = (vcount_q >= V_LAST) ? 11'd0 : vcount_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= (hcount_d >= H_BLK);
            hsync_q       <= (hcount_d >= H_SYN_LO) && (hcount_d < H_SYN_HI);
            vblnk_q       <= (vcount_d >= V_BLK);
            vsync_q       <= (vcount_d >= V_SYN_LO) && (vcount_d < V_SYN_HI);
            line_start_q  <= (hcount_d == 11'd0);
            frame_start_q <= (hcount_d == 11'd0) && (vcount_d == 11'd0);
        end
    end

    assign vga_out.hcount = hcount_q;
    assign vga_out.vcount = vcount_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = 12'h000;
    assign frame_start    = frame_start_q;
    assign line_start     = line_start_q;
endmodule
